hilo_mdu_ctrl: RTL

- Multiply/divide sequencer that owns and updates the HI and LO special registers of the MIPS54 CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage.
- Multiplies and moves complete in one cycle. Divides run as a 32-iteration restoring sequence plus one sign-fix cycle.
- busy tells the pipeline to stall until HI/LO are valid.

---
 rtl/hilo_mdu_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply-divide sequencer.
// Multiplies and moves complete in one cycle. Divides use a 32-step restoring
// sequence plus one sign-fix cycle. busy stalls the pipeline until HI/LO are valid.
module hilo_mdu_ctrl #(
    parameter logic [31:0] HI_INIT = 32'h0000_0000,
    parameter logic [31:0] LO_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StDivRun, StDivFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;
    logic [31:0] dvd_q;   // dividend magnitude, shifted out MSB-first; becomes the quotient
    logic [31:0] dvs_q;   // divisor magnitude
    logic [31:0] rem_q;   // partial remainder
    logic [31:0] raw_rs_q;
    logic        qsign_q, rsign_q, dvz_q;

    logic        accept, is_div, is_mul, is_signed_div;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] shifted;
    logic        step_sub;
    logic [31:0] rem_next;

    // Command decode, shared multiplier and operand magnitudes.
    always_comb begin
        accept        = start && (state_q == StIdle);
        is_mul        = (op == OpMult) || (op == OpMultu);
        is_div        = (op == OpDiv) || (op == OpDivu);
        is_signed_div = (op == OpDiv);
        // Sign-extending for MULT makes the low 64 bits of the product the signed result.
        mul_a  = {{32{(op == OpMult) && rs_data[31]}}, rs_data};
        mul_b  = {{32{(op == OpMult) && rt_data[31]}}, rt_data};
        prod   = mul_a * mul_b;
        rs_mag = (is_signed_div && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
        rt_mag = (is_signed_div && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;
    end

    // One restoring-division step.
    always_comb begin
        shifted  = {rem_q, dvd_q[31]};
        step_sub = shifted >= {1'b0, dvs_q};
        // Remainder is always below the divisor, so the difference fits in 32 bits.
        rem_next = step_sub ? (shifted[31:0] - dvs_q) : shifted[31:0];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept && is_div) state_d = StDivRun;
            StDivRun: if (cnt_q == 5'd31) state_d = StDivFix;
            StDivFix: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // HI/LO, divide datapath and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q     <= HI_INIT;
            lo_q     <= LO_INIT;
            done_q   <= 1'b0;
            cnt_q    <= 5'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            rem_q    <= 32'd0;
            raw_rs_q <= 32'd0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            dvz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (is_mul) begin
                            {hi_q, lo_q} <= prod;
                            done_q       <= 1'b1;
                        end else if (op == OpMthi) begin
                            hi_q   <= rs_data;
                            done_q <= 1'b1;
                        end else if (op == OpMtlo) begin
                            lo_q   <= rs_data;
                            done_q <= 1'b1;
                        end else if (is_div) begin
                            dvd_q    <= rs_mag;
                            dvs_q    <= rt_mag;
                            rem_q    <= 32'd0;
                            raw_rs_q <= rs_data;
                            qsign_q  <= is_signed_div && (rs_data[31] ^ rt_data[31]);
                            rsign_q  <= is_signed_div && rs_data[31];
                            dvz_q    <= (rt_data == 32'd0);
                            cnt_q    <= 5'd0;
                        end
                    end
                end
                StDivRun: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[30:0], step_sub};
                    cnt_q <= cnt_q + 5'd1;
                end
                StDivFix: begin
                    if (dvz_q) begin
                        lo_q <= 32'hFFFF_FFFF;
                        hi_q <= raw_rs_q;
                    end else begin
                        lo_q <= qsign_q ? (~dvd_q + 32'd1) : dvd_q;
                        hi_q <= rsign_q ? (~rem_q + 32'd1) : rem_q;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
